// File: rtl/light_max_detector_if.sv
// rtl/light_max_detector_if.sv - control, ADC sample and max-report signals of light_max_detector
interface light_max_detector_if #(
    parameter int DATA_W = 12
);
    logic              EN;
    logic              CLR;
    logic [DATA_W-1:0] ADC_DATA;
    logic              ADC_VALID;
    logic              CNT_RST;
    logic [DATA_W-1:0] MAX_VAL;
    logic              MAX_VLD;

    modport master (
        output EN, CLR, ADC_DATA, ADC_VALID,
        input  CNT_RST, MAX_VAL, MAX_VLD
    );

    modport slave (
        input  EN, CLR, ADC_DATA, ADC_VALID,
        output CNT_RST, MAX_VAL, MAX_VLD
    );
endinterface

// File: rtl/light_max_detector.sv
// rtl/light_max_detector.sv - running-max tracker with hysteresis and confirmation, pulses CNT_RST on new max
module light_max_detector #(
    parameter int DATA_W  = 12,
    parameter int HYST    = 4,
    parameter int CONFIRM = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    light_max_detector_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        CONF  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] max_val_q;
    logic              max_vld_q;
    logic              cnt_rst_q;
    logic [DATA_W-1:0] cand_q;
    logic [3:0]        cnt_q;

    logic [DATA_W:0]   thr;
    logic              qual;
    logic [DATA_W-1:0] min_cand;
    logic [3:0]        cnt_inc;

    // One extra bit keeps the threshold from wrapping near full scale.
    assign thr      = {1'b0, max_val_q} + (DATA_W+1)'(HYST);
    assign qual     = {1'b0, bus.ADC_DATA} > thr;
    assign min_cand = (bus.ADC_DATA < cand_q) ? bus.ADC_DATA : cand_q;
    assign cnt_inc  = cnt_q + 4'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            max_val_q <= '0;
            max_vld_q <= 1'b0;
            cnt_rst_q <= 1'b0;
            cand_q    <= '0;
            cnt_q     <= '0;
        end else begin
            cnt_rst_q <= 1'b0;
            if (bus.CLR) begin
                max_val_q <= '0;
                max_vld_q <= 1'b0;
                cand_q    <= '0;
                cnt_q     <= '0;
                state_q   <= bus.EN ? TRACK : IDLE;
            end else if (!bus.EN) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= TRACK;
                    end
                    TRACK: begin
                        if (bus.ADC_VALID) begin
                            if (!max_vld_q) begin
                                max_val_q <= bus.ADC_DATA;
                                max_vld_q <= 1'b1;
                                cnt_rst_q <= 1'b1;
                            end else if (qual) begin
                                if (CONFIRM == 1) begin
                                    max_val_q <= bus.ADC_DATA;
                                    cnt_rst_q <= 1'b1;
                                end else begin
                                    cand_q  <= bus.ADC_DATA;
                                    cnt_q   <= 4'd1;
                                    state_q <= CONF;
                                end
                            end
                        end
                    end
                    CONF: begin
                        if (bus.ADC_VALID) begin
                            if (qual) begin
                                // Accept the smallest confirming sample so a single spike cannot inflate the max.
                                if (cnt_inc == 4'(CONFIRM)) begin
                                    max_val_q <= min_cand;
                                    cnt_rst_q <= 1'b1;
                                    cnt_q     <= '0;
                                    state_q   <= TRACK;
                                end else begin
                                    cand_q <= min_cand;
                                    cnt_q  <= cnt_inc;
                                end
                            end else begin
                                cnt_q   <= '0;
                                state_q <= TRACK;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.CNT_RST = cnt_rst_q;
    assign bus.MAX_VAL = max_val_q;
    assign bus.MAX_VLD = max_vld_q;
endmodule
